// File: rtl/pc_stack.sv
// Program counter with relative branch, call/return through a small
// hardware return-address stack, and sticky overflow/underflow flags.
// All state advances only in the sequencer's update slot; error clearing
// is accepted on any enabled clock.
module pc_stack #(
    parameter int                ADDR_W       = 12,
    parameter int                CYC_W        = 3,
    parameter int                UPDATE_CYCLE = 7,
    parameter int                STACK_DEPTH  = 4,
    parameter int                SP_W         = 3,
    parameter logic [ADDR_W-1:0] RESET_VEC    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpuCe,
    input  logic [CYC_W-1:0]  cycle,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jumpAddr,
    input  logic              call,
    input  logic              ret,
    input  logic              branch,
    input  logic [7:0]        relOffset,
    input  logic              clrErr,
    output logic [ADDR_W-1:0] pcount,
    output logic [SP_W-1:0]   sp,
    output logic              stackEmpty,
    output logic              stackFull,
    output logic              ovfErr,
    output logic              unfErr
);

    localparam int              IDX_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [CYC_W-1:0] SLOT_CYC = CYC_W'(UPDATE_CYCLE);

    // Wrapping increment of a program-counter value.
    function automatic logic [ADDR_W-1:0] pc_plus1(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

    // Wrapping add of a sign-extended 8-bit branch displacement.
    function automatic logic [ADDR_W-1:0] pc_rel(input logic [ADDR_W-1:0] pc,
                                                 input logic signed [7:0] off);
        logic signed [ADDR_W-1:0] ext;
        ext = ADDR_W'(off);
        return pc + ext;
    endfunction

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic              slot;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [SP_W-1:0]   sp_nxt;
    logic              push;
    logic              ovf_set;
    logic              unf_set;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign slot   = cpuCe && (cycle == SLOT_CYC);
    assign pc_inc = pc_plus1(pcount);
    assign wr_idx = IDX_W'(sp);
    assign rd_idx = IDX_W'(sp - SP_W'(1));

    // Resolve the single action of an update slot: ret > call > jump > branch > increment.
    always_comb begin
        pc_nxt  = pcount;
        sp_nxt  = sp;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (slot) begin
            if (ret) begin
                if (sp != '0) begin
                    pc_nxt = stack_mem[rd_idx];
                    sp_nxt = sp - SP_W'(1);
                end else begin
                    pc_nxt  = pc_inc;
                    unf_set = 1'b1;
                end
            end else if (call) begin
                // Target is taken even when the push is refused.
                pc_nxt = jumpAddr;
                if (sp < SP_FULL) begin
                    push   = 1'b1;
                    sp_nxt = sp + SP_W'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (jump) begin
                pc_nxt = jumpAddr;
            end else if (branch) begin
                pc_nxt = pc_rel(pcount, relOffset);
            end else begin
                pc_nxt = pc_inc;
            end
        end
    end

    // Program counter and stack pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcount <= RESET_VEC;
            sp     <= '0;
        end else begin
            pcount <= pc_nxt;
            sp     <= sp_nxt;
        end
    end

    // Return-address storage; a push writes the address after the call.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
        end else if (push) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end

    // Sticky error flags; a new error on the same edge beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovfErr <= 1'b0;
            unfErr <= 1'b0;
        end else if (cpuCe) begin
            if (ovf_set)     ovfErr <= 1'b1;
            else if (clrErr) ovfErr <= 1'b0;
            if (unf_set)     unfErr <= 1'b1;
            else if (clrErr) unfErr <= 1'b0;
        end
    end

    assign stackEmpty = (sp == '0);
    assign stackFull  = (sp == SP_FULL);

endmodule
